// File: rtl/taxi_xgmii_baser_enc_32.sv
// ============================================================================
// taxi_xgmii_baser_enc_32
//
// 10GBASE-R 64b/66b encoder with a 32-bit datapath. Consecutive valid XGMII
// words are paired into one 64-bit block (first word = lanes 0-3, second word
// = lanes 4-7). The block is classified and emitted as two 32-bit payload
// words. The 2-bit sync header goes out with the first word. This block does
// not scramble; its output feeds the PCS TX scrambler/gearbox.
//
// Ports
//   clk                    in   1   single clock domain
//   rst                    in   1   synchronous reset, active-high
//   xgmii_txd              in  32   XGMII data, lane 0 = [7:0]
//   xgmii_txc              in   4   XGMII control, bit n flags lane n
//   xgmii_tx_valid         in   1   input word valid (low = gearbox pause)
//   encoded_tx_data        out 32   block payload word
//   encoded_tx_data_valid  out  1   xgmii_tx_valid delayed by one cycle
//   encoded_tx_hdr         out  2   sync header, 2'b01 data, 2'b10 control
//   encoded_tx_hdr_valid   out  1   high with the first word of each block
//
// Timing
//   Phase-0 word accepted  -> captured. The output shows the second word of
//                             the previous block, or 0 after reset.
//   Phase-1 word accepted  -> block encoded and registered. The output shows
//                             the first word with hdr_valid=1.
//   A cycle with valid=0 holds all state. It drops both valids, and the data
//   and header outputs keep their values.
// ============================================================================

module taxi_xgmii_baser_enc_32 #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = DATA_W/8,
   parameter int HDR_W  = 2
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [DATA_W-1:0] xgmii_txd,
   input  logic [CTRL_W-1:0] xgmii_txc,
   input  logic              xgmii_tx_valid,

   output logic [DATA_W-1:0] encoded_tx_data,
   output logic              encoded_tx_data_valid,
   output logic [HDR_W-1:0]  encoded_tx_hdr,
   output logic              encoded_tx_hdr_valid
);

   // -------------------------------------------------------------------------
   // Parameter guard: the block layout below is hard-wired for 32/4/2.
   // -------------------------------------------------------------------------
   if (DATA_W != 32 || CTRL_W != DATA_W/8 || HDR_W != 2) begin : g_bad_params
      $error("taxi_xgmii_baser_enc_32: only DATA_W=32, CTRL_W=4, HDR_W=2 supported");
   end

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam logic [7:0] CH_IDLE  = 8'h07;
   localparam logic [7:0] CH_ERR   = 8'hFE;
   localparam logic [7:0] CH_START = 8'hFB;
   localparam logic [7:0] CH_TERM  = 8'hFD;
   localparam logic [7:0] CH_SEQ   = 8'h9C;

   localparam logic [6:0] CODE_IDLE = 7'h00;
   localparam logic [6:0] CODE_ERR  = 7'h1E;

   localparam logic [7:0] TYPE_CTRL = 8'h1E;
   localparam logic [7:0] TYPE_S0   = 8'h78;
   localparam logic [7:0] TYPE_S4   = 8'h33;
   localparam logic [7:0] TYPE_Q    = 8'h4B;

   // Terminate block types indexed by T lane: byte k is the type for lane k.
   localparam logic [63:0] TERM_TYPES = 64'hFF_E1_D2_CC_B4_AA_99_87;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   // Substitute for any block that matches no legal format.
   localparam logic [63:0] BLOCK_INVALID = {{8{CODE_ERR}}, TYPE_CTRL};

   typedef struct packed {
      logic [1:0]  hdr;
      logic [63:0] payload;
   } enc_t;

   typedef enum logic {
      PHASE_LOW  = 1'b0,   // next valid word carries lanes 0-3
      PHASE_HIGH = 1'b1    // next valid word carries lanes 4-7
   } phase_t;

   // -------------------------------------------------------------------------
   // Block encoder
   //
   // Each block is encoded on its own. A block is legal only if it matches one
   // of the formats below exactly. Anything else becomes BLOCK_INVALID. That
   // covers unknown control characters, S/T/Q in the wrong lane, data after T,
   // and T followed by S in the same block.
   // -------------------------------------------------------------------------
   function automatic enc_t encode_block(input logic [63:0] d, input logic [7:0] c);
      enc_t        r;
      logic [7:0]  lane;
      logic [7:0]  idle_m;
      logic [7:0]  err_m;
      logic [7:0]  start_m;
      logic [7:0]  term_m;
      logic [7:0]  seq_m;
      logic [7:0]  term_ctrl;
      logic [7:0]  after_term;
      logic [55:0] codes;

      for (int i = 0; i < 8; i++) begin
         lane       = d[8*i +: 8];
         idle_m[i]  = c[i] && (lane == CH_IDLE);
         err_m[i]   = c[i] && (lane == CH_ERR);
         start_m[i] = c[i] && (lane == CH_START);
         term_m[i]  = c[i] && (lane == CH_TERM);
         seq_m[i]   = c[i] && (lane == CH_SEQ);
         // 7-bit code for each lane, packed LSB-first. These codes are only
         // used where the lanes in question are known to be /I/ or /E/.
         codes[7*i +: 7] = idle_m[i] ? CODE_IDLE : CODE_ERR;
      end

      // NOTE: every output of this combinational function gets a value before
      // any branch, so no path leaves it unassigned and no latch can be
      // inferred where it is used.
      r.hdr     = SYNC_CTRL;
      r.payload = BLOCK_INVALID;

      if (c == 8'h00) begin
         // Pure data block: payload passes through unchanged.
         r.hdr     = SYNC_DATA;
         r.payload = d;
      end else if ((idle_m | err_m) == 8'hFF) begin
         // All control, idle/error only.
         r.payload = {codes, TYPE_CTRL};
      end else if (c == 8'h01 && start_m[0]) begin
         // Start in lane 0, D1..D7 follow.
         r.payload = {d[63:8], TYPE_S0};
      end else if (c == 8'h1F && start_m[4] && ((idle_m[3:0] | err_m[3:0]) == 4'hF)) begin
         // Idles/errors in lanes 0-3, start in lane 4. Four pad bits sit
         // between the codes and D5..D7.
         r.payload = {d[63:40], 4'h0, codes[27:0], TYPE_S4};
      end else if (c == 8'hF1 && seq_m[0] && (idle_m[7:4] == 4'hF)) begin
         // Ordered set in lane 0. O-code is 0 and the four idle codes are 0.
         r.payload = {28'h0, 4'h0, d[31:8], TYPE_Q};
      end else begin
         // Terminate in lane k: lanes below k are data, lanes above k are
         // idle. The control mask for that shape is 8'hFF << k. At most one
         // k can match a given mask.
         for (int k = 0; k < 8; k++) begin
            term_ctrl  = 8'hFF << k;
            after_term = 8'hFF << (k + 1);
            if (c == term_ctrl && term_m[k] && ((idle_m & after_term) == after_term)) begin
               // Idle codes after T are all zero, so only the data bytes and
               // the type byte are nonzero.
               r.payload = {56'h0, TERM_TYPES[8*k +: 8]};
               for (int j = 0; j < 7; j++) begin
                  if (j < k) begin
                     r.payload[8*(j+1) +: 8] = d[8*j +: 8];
                  end
               end
            end
         end
      end

      return r;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   phase_t      phase;
   logic [31:0] low_data;    // phase-0 capture, lanes 0-3 data
   logic [3:0]  low_ctrl;    // phase-0 capture, lanes 0-3 control
   logic [31:0] pend_word;   // second payload word, sent on the next valid cycle
   enc_t        enc;

   // The block completes with the word on the input this cycle.
   assign enc = encode_block({xgmii_txd, low_data}, {xgmii_txc, low_ctrl});

   // -------------------------------------------------------------------------
   // Phase FSM and registered outputs
   // -------------------------------------------------------------------------
   // NOTE: all state in this block uses non-blocking assignments. Every
   // right-hand side then sees the pre-edge values, whatever the statement
   // order.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase                 <= PHASE_LOW;
         low_data              <= '0;
         low_ctrl              <= '0;
         pend_word             <= '0;
         encoded_tx_data       <= '0;
         encoded_tx_data_valid <= 1'b0;
         encoded_tx_hdr        <= '0;
         encoded_tx_hdr_valid  <= 1'b0;
      end else begin
         encoded_tx_data_valid <= xgmii_tx_valid;
         encoded_tx_hdr_valid  <= 1'b0;

         if (xgmii_tx_valid) begin
            case (phase)
               PHASE_LOW: begin
                  // Capture lanes 0-3. Release the previous block's second
                  // word in the same cycle.
                  low_data        <= xgmii_txd;
                  low_ctrl        <= xgmii_txc;
                  encoded_tx_data <= pend_word;
                  phase           <= PHASE_HIGH;
               end
               PHASE_HIGH: begin
                  encoded_tx_data      <= enc.payload[31:0];
                  encoded_tx_hdr       <= enc.hdr;
                  encoded_tx_hdr_valid <= 1'b1;
                  pend_word            <= enc.payload[63:32];
                  phase                <= PHASE_LOW;
               end
               default: begin
                  phase <= PHASE_LOW;
               end
            endcase
         end
      end
   end

endmodule
